div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_div_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One operation in flight; the request is accepted in IDLE and the response
// is held in DONE until the consumer takes it.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip the iteration loop and complete two edges after acceptance.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. The producer keeps its payload stable while valid && !ready. On
// the response side, resp_result/resp_rd are stable for as long as
// resp_valid is 1.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic [4:0]      resp_rd,
    output logic            busy,
    output logic [2:0]      dbg_state
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] quo_q, quo_d;      // dividend on entry, quotient at the end
    logic [XLEN-1:0] div_q, div_d;      // divisor (magnitude after PREP)
    logic [XLEN-1:0] rem_q, rem_d;      // partial remainder
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [4:0]      resp_rd_q, resp_rd_d;

    // Combinational helpers for the datapath
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            b_zero;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign req_ready   = (state_q == IDLE) && !flush;
    assign busy        = (state_q != IDLE);
    assign resp_valid  = (state_q == DONE);
    assign resp_result = res_q;
    assign resp_rd     = resp_rd_q;
    assign dbg_state   = state_q;

    // Operand conditioning, trial subtraction and final sign correction
    always_comb begin
        signed_op = ~op_q[0];
        a_neg     = signed_op & quo_q[XLEN-1];
        b_neg     = signed_op & div_q[XLEN-1];
        a_abs     = a_neg ? (~quo_q + 1'b1) : quo_q;
        b_abs     = b_neg ? (~div_q + 1'b1) : div_q;
        b_zero    = (div_q == '0);
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = shifted - {1'b0, div_q};
        q_fix     = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        r_fix     = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        quo_d     = quo_q;
        div_d     = div_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        res_d     = res_q;
        resp_rd_d = resp_rd_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    rd_d    = req_rd;
                    quo_d   = req_a;
                    div_d   = req_b;
                    state_d = PREP;
                end
            end
            PREP: begin
                quo_d   = a_abs;
                div_d   = b_abs;
                rem_d   = '0;
                cnt_d   = '0;
                // A zero divisor yields all-ones regardless of operand signs,
                // so its quotient must never be negated.
                q_neg_d = (a_neg ^ b_neg) & ~b_zero;
                r_neg_d = a_neg;
                state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
                // Preload the architectural result and reuse FIX for the
                // sign/select step, giving a two-edge turnaround.
                if (b_zero) begin
                    quo_d   = '1;
                    rem_d   = a_abs;
                    state_d = FIX;
                end else if (signed_op && (quo_q == {1'b1, {(XLEN-1){1'b0}}}) &&
                             (div_q == '1)) begin
                    quo_d   = quo_q;
                    rem_d   = '0;
                    q_neg_d = 1'b0;
                    state_d = FIX;
                end
`endif
            end
            CALC: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res_d     = op_q[1] ? r_fix : q_fix;
                resp_rd_d = rd_q;
                state_d   = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush discards whatever is in flight, including a pending response.
        if (flush) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            res_q     <= '0;
            resp_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            res_q     <= res_d;
            resp_rd_q <= resp_rd_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer (XLEN = 32).
module tb_div_sequencer;

    localparam int XLEN = 32;
    localparam int FULL_LAT = XLEN + 2;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = XLEN + 2;
`endif

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_op = '0;
    logic [XLEN-1:0] req_a = '0;
    logic [XLEN-1:0] req_b = '0;
    logic [4:0]      req_rd = '0;
    logic            flush = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [XLEN-1:0] resp_result;
    logic [4:0]      resp_rd;
    logic            busy;
    logic [2:0]      dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rd     (req_rd),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .resp_rd    (resp_rd),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Present a request and let the next rising edge accept it.
    task automatic accept_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'h1234_5678;
        req_rd    = 5'h1F;
    endtask

    // Count edges after acceptance until resp_valid; lat = -1 on timeout.
    task automatic wait_resp(output int lat, output logic [XLEN-1:0] res,
                             output logic [4:0] rdo);
        lat = 0;
        while (!resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) lat = -1;
        res = resp_result;
        rdo = resp_rd;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [4:0] rd,
                          output int lat, output logic [XLEN-1:0] res,
                          output logic [4:0] rdo);
        accept_op(op, a, b, rd);
        wait_resp(lat, res, rdo);
    endtask

    // One edge with resp_ready held at 1 takes the response.
    task automatic consume();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int lat;
        logic [XLEN-1:0] res;
        logic [4:0] rdo;
        #3;
        tests_run++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_result !== '0 ||
            resp_rd !== '0 || dbg_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b busy=%b result=%h rd=%h state=%0d, expected all zero",
                     resp_valid, busy, resp_result, resp_rd, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        // Accepted on the first edge after release: full latency DIVU 100/7.
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd3, lat, res, rdo);
        tests_run++;
        if (lat !== FULL_LAT || res !== 32'd14 || rdo !== 5'd3) begin
            tests_failed++;
            $display("FAIL divu_100_7: lat=%0d res=%0d rd=%0d expected lat=%0d res=14 rd=3",
                     lat, res, rdo, FULL_LAT);
        end
        consume();
    endtask

    task automatic test_unsigned();
        int lat;
        logic [XLEN-1:0] res;
        logic [4:0] rdo;
        run_op(OP_REMU, 32'd100, 32'd7, 5'd4, lat, res, rdo);
        tests_run++;
        if (lat !== FULL_LAT || res !== 32'd2 || rdo !== 5'd4) begin
            tests_failed++;
            $display("FAIL remu_100_7: lat=%0d res=%0d rd=%0d expected lat=%0d res=2 rd=4",
                     lat, res, rdo, FULL_LAT);
        end
        consume();
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd5, lat, res, rdo);
        tests_run++;
        if (lat !== FULL_LAT || res !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL divu_max_1: lat=%0d res=%h expected lat=%0d res=ffffffff",
                     lat, res, FULL_LAT);
        end
        consume();
    endtask

    task automatic test_signed();
        logic [1:0]      ops [4];
        logic [XLEN-1:0] as  [4];
        logic [XLEN-1:0] bs  [4];
        logic [XLEN-1:0] exps[4];
        int lat;
        logic [XLEN-1:0] res;
        logic [4:0] rdo;
        ops[0] = OP_DIV; as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;         exps[0] = 32'hFFFF_FFFD;
        ops[1] = OP_REM; as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2;         exps[1] = 32'hFFFF_FFFF;
        ops[2] = OP_REM; as[2] = 32'd7;         bs[2] = 32'hFFFF_FFFE; exps[2] = 32'd1;
        ops[3] = OP_DIV; as[3] = 32'd7;         bs[3] = 32'hFFFF_FFFE; exps[3] = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 8), lat, res, rdo);
            tests_run++;
            if (lat !== FULL_LAT || res !== exps[i] || rdo !== 5'(i + 8)) begin
                tests_failed++;
                $display("FAIL signed_%0d: lat=%0d res=%h rd=%0d expected lat=%0d res=%h rd=%0d",
                         i, lat, res, rdo, FULL_LAT, exps[i], i + 8);
            end
            consume();
        end
    endtask

    task automatic test_special();
        logic [1:0]      ops [5];
        logic [XLEN-1:0] as  [5];
        logic [XLEN-1:0] bs  [5];
        logic [XLEN-1:0] exps[5];
        int lat;
        logic [XLEN-1:0] res;
        logic [4:0] rdo;
        ops[0] = OP_DIVU; as[0] = 32'd5;         bs[0] = 32'd0;         exps[0] = 32'hFFFF_FFFF;
        ops[1] = OP_REMU; as[1] = 32'd5;         bs[1] = 32'd0;         exps[1] = 32'd5;
        ops[2] = OP_DIV;  as[2] = 32'hFFFF_FFFB; bs[2] = 32'd0;         exps[2] = 32'hFFFF_FFFF;
        ops[3] = OP_REM;  as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF; exps[3] = 32'd0;
        ops[4] = OP_DIV;  as[4] = 32'h8000_0000; bs[4] = 32'hFFFF_FFFF; exps[4] = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 16), lat, res, rdo);
            tests_run++;
            if (lat !== SPEC_LAT || res !== exps[i] || rdo !== 5'(i + 16)) begin
                tests_failed++;
                $display("FAIL special_%0d: lat=%0d res=%h rd=%0d expected lat=%0d res=%h rd=%0d",
                         i, lat, res, rdo, SPEC_LAT, exps[i], i + 16);
            end
            consume();
        end
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        logic [XLEN-1:0] res;
        logic [4:0] rdo;
        accept_op(OP_DIVU, 32'd1000, 32'd3, 5'd9);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (dbg_state !== 3'd2 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_in_calc: state=%0d busy=%b expected state=2 busy=1", dbg_state, busy);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || dbg_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL flush_idle: busy=%b valid=%b state=%0d expected 0 0 0", busy, resp_valid, dbg_state);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL flush_no_resp: resp_valid cycles=%0d expected 0", seen);
        end
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd10, lat, res, rdo);
        tests_run++;
        if (lat !== FULL_LAT || res !== 32'd14 || rdo !== 5'd10) begin
            tests_failed++;
            $display("FAIL flush_next_op: lat=%0d res=%0d rd=%0d expected lat=%0d res=14 rd=10",
                     lat, res, rdo, FULL_LAT);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [XLEN-1:0] res;
        logic [4:0] rdo;
        resp_ready = 1'b0;
        run_op(OP_REMU, 32'd50, 32'd8, 5'd21, lat, res, rdo);
        tests_run++;
        if (lat !== FULL_LAT || res !== 32'd2 || rdo !== 5'd21) begin
            tests_failed++;
            $display("FAIL stall_first: lat=%0d res=%0d rd=%0d expected lat=%0d res=2 rd=21",
                     lat, res, rdo, FULL_LAT);
        end
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b1 || resp_result !== 32'd2 || resp_rd !== 5'd21 ||
                req_ready !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL stall_hold: unstable cycles=%0d expected 0", bad);
        end
        // Flush together with the handshake: no response afterwards.
        flush = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bad = 0;
        repeat (5) begin
            if (resp_valid !== 1'b0 || busy !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL flush_with_take: busy/valid cycles=%0d expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [XLEN-1:0] res;
        logic [4:0] rdo;
        run_op(OP_DIVU, 32'd81, 32'd9, 5'd1, lat, res, rdo);
        tests_run++;
        if (lat !== FULL_LAT || res !== 32'd9) begin
            tests_failed++;
            $display("FAIL b2b_first: lat=%0d res=%0d expected lat=%0d res=9", lat, res, FULL_LAT);
        end
        // Next request already waiting while the response completes.
        req_valid = 1'b1;
        req_op    = OP_REMU;
        req_a     = 32'd81;
        req_b     = 32'd10;
        req_rd    = 5'd2;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_accept_on_done: busy=%b valid=%b expected 0 0", busy, resp_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp(lat, res, rdo);
        tests_run++;
        if (lat !== FULL_LAT || res !== 32'd1 || rdo !== 5'd2) begin
            tests_failed++;
            $display("FAIL b2b_second: lat=%0d res=%0d rd=%0d expected lat=%0d res=1 rd=2",
                     lat, res, rdo, FULL_LAT);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [XLEN-1:0] res;
        logic [4:0] rdo;
        accept_op(OP_DIVU, 32'd77, 32'd5, 5'd12);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_result !== '0 ||
            resp_rd !== '0 || dbg_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b busy=%b result=%h rd=%h state=%0d expected all zero",
                     resp_valid, busy, resp_result, resp_rd, dbg_state);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid || busy) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_stale: active cycles=%0d expected 0", seen);
        end
        run_op(OP_DIVU, 32'd9, 32'd3, 5'd13, lat, res, rdo);
        tests_run++;
        if (lat !== FULL_LAT || res !== 32'd3 || rdo !== 5'd13) begin
            tests_failed++;
            $display("FAIL reset_next_op: lat=%0d res=%0d rd=%0d expected lat=%0d res=3 rd=13",
                     lat, res, rdo, FULL_LAT);
        end
        consume();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
